// File: rtl/debounce_edge.sv
// Debouncer for a raw asynchronous 1-bit input: 2-flop synchronizer, counter-qualified
// 4-state FSM, registered level output and one-cycle rise/fall strobes.
module debounce_edge #(
    parameter int STABLE_CNT = 4,
    parameter int CNT_W      = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall
);

    typedef enum logic [1:0] {
        LO,
        WAIT_HI,
        HI,
        WAIT_LO
    } state_t;

    // The sample that enters a WAIT state already counts as the first stable one,
    // so qualification happens when the counter holds STABLE_CNT-1.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CNT - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
    localparam bit               DIRECT   = (STABLE_CNT == 1);

    state_t           state;
    state_t           state_next;
    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             q_next;
    logic             rise_next;
    logic             fall_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            state <= LO;
            cnt   <= '0;
            q     <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            s1    <= din;
            s2    <= s1;
            state <= state_next;
            cnt   <= cnt_next;
            q     <= q_next;
            rise  <= rise_next;
            fall  <= fall_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = '0;
        q_next     = q;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        case (state)
            LO: begin
                if (s2) begin
                    if (DIRECT) begin
                        state_next = HI;
                        q_next     = 1'b1;
                        rise_next  = 1'b1;
                    end else begin
                        state_next = WAIT_HI;
                        cnt_next   = ONE_CNT;
                    end
                end
            end
            WAIT_HI: begin
                if (!s2) begin
                    state_next = LO;
                end else if (cnt == LAST_CNT) begin
                    state_next = HI;
                    q_next     = 1'b1;
                    rise_next  = 1'b1;
                end else begin
                    cnt_next = cnt + ONE_CNT;
                end
            end
            HI: begin
                if (!s2) begin
                    if (DIRECT) begin
                        state_next = LO;
                        q_next     = 1'b0;
                        fall_next  = 1'b1;
                    end else begin
                        state_next = WAIT_LO;
                        cnt_next   = ONE_CNT;
                    end
                end
            end
            WAIT_LO: begin
                if (s2) begin
                    state_next = HI;
                end else if (cnt == LAST_CNT) begin
                    state_next = LO;
                    q_next     = 1'b0;
                    fall_next  = 1'b1;
                end else begin
                    cnt_next = cnt + ONE_CNT;
                end
            end
            default: begin
                state_next = LO;
                q_next     = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_debounce_edge.sv
// Bench for debounce_edge: three parameterisations share one input stream and are
// compared every cycle against a sample-history model of the debounce rule.
module tb_debounce_edge;

    localparam int NUM_DUT = 3;
    localparam int K0 = 4;
    localparam int K1 = 1;
    localparam int K2 = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din = 1'b1;
    logic q    [NUM_DUT];
    logic rise [NUM_DUT];
    logic fall [NUM_DUT];

    int assert_count = 0;
    int fail_count   = 0;

    always #100 clk = ~clk;

    debounce_edge #(.STABLE_CNT(K0), .CNT_W(4)) u_def (
        .clk(clk), .rst(rst), .din(din), .q(q[0]), .rise(rise[0]), .fall(fall[0])
    );
    debounce_edge #(.STABLE_CNT(K1), .CNT_W(4)) u_one (
        .clk(clk), .rst(rst), .din(din), .q(q[1]), .rise(rise[1]), .fall(fall[1])
    );
    debounce_edge #(.STABLE_CNT(K2), .CNT_W(4)) u_max (
        .clk(clk), .rst(rst), .din(din), .q(q[2]), .rise(rise[2]), .fall(fall[2])
    );

    // Reference: q toggles once the last K synchronized samples since reset or the
    // previous toggle all disagree with q; the toggle edge also raises the strobe.
    int          k_val    [NUM_DUT] = '{K0, K1, K2};
    logic        m_s1 = 1'b0;
    logic        m_s2 = 1'b0;
    logic        seen;
    logic        m_q      [NUM_DUT] = '{1'b0, 1'b0, 1'b0};
    logic        m_rise   [NUM_DUT] = '{1'b0, 1'b0, 1'b0};
    logic        m_fall   [NUM_DUT] = '{1'b0, 1'b0, 1'b0};
    logic [15:0] hist     [NUM_DUT] = '{16'd0, 16'd0, 16'd0};
    int          hist_len [NUM_DUT] = '{0, 0, 0};
    logic [15:0] mask;

    always @(posedge clk) begin
        if (rst) begin
            m_s1 = 1'b0;
            m_s2 = 1'b0;
            for (int i = 0; i < NUM_DUT; i++) begin
                m_q[i]      = 1'b0;
                m_rise[i]   = 1'b0;
                m_fall[i]   = 1'b0;
                hist_len[i] = 0;
            end
        end else begin
            seen = m_s2;
            m_s2 = m_s1;
            m_s1 = din;
            for (int i = 0; i < NUM_DUT; i++) begin
                m_rise[i]   = 1'b0;
                m_fall[i]   = 1'b0;
                hist[i]     = {hist[i][14:0], seen};
                hist_len[i] = hist_len[i] + 1;
                mask        = 16'((32'd1 << k_val[i]) - 1);
                if (hist_len[i] >= k_val[i] &&
                    ((!m_q[i] && (hist[i] & mask) == mask) ||
                     ( m_q[i] && (hist[i] & mask) == 16'd0))) begin
                    m_q[i]      = ~m_q[i];
                    m_rise[i]   = m_q[i];
                    m_fall[i]   = ~m_q[i];
                    hist_len[i] = 0;
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed %b, expected %b at time %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkAll();
        for (int i = 0; i < NUM_DUT; i++) begin
            checkOutput($sformatf("q[%0d]", i), q[i], m_q[i]);
            checkOutput($sformatf("rise[%0d]", i), rise[i], m_rise[i]);
            checkOutput($sformatf("fall[%0d]", i), fall[i], m_fall[i]);
            checkOutput($sformatf("rise_and_fall[%0d]", i), rise[i] & fall[i], 1'b0);
        end
    endtask

    // Inputs change right after a check on the falling edge, so each value is
    // captured by the following rising edge.
    task automatic applyStimulus(input logic r, input logic d, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            rst = r;
            din = d;
            @(negedge clk);
            checkAll();
        end
    endtask

    initial begin
        int   run_len;
        logic rnd_din;

        $display("[TB] reset with din held high");
        applyStimulus(1'b1, 1'b1, 2);
        applyStimulus(1'b0, 1'b1, 20);

        $display("[TB] release");
        applyStimulus(1'b0, 1'b0, 20);

        $display("[TB] clean press");
        applyStimulus(1'b0, 1'b1, 20);
        applyStimulus(1'b0, 1'b0, 20);

        $display("[TB] bounce then hold");
        applyStimulus(1'b0, 1'b1, 1);
        applyStimulus(1'b0, 1'b0, 1);
        applyStimulus(1'b0, 1'b1, 2);
        applyStimulus(1'b0, 1'b0, 1);
        applyStimulus(1'b0, 1'b1, 20);
        applyStimulus(1'b0, 1'b0, 20);

        $display("[TB] reset mid-qualification");
        applyStimulus(1'b0, 1'b1, 3);
        applyStimulus(1'b1, 1'b1, 1);
        applyStimulus(1'b0, 1'b1, 20);

        $display("[TB] 14-cycle glitch");
        applyStimulus(1'b0, 1'b0, 20);
        applyStimulus(1'b0, 1'b1, 14);
        applyStimulus(1'b0, 1'b0, 20);

        $display("[TB] randomized segments");
        for (int s = 0; s < 60; s++) begin
            run_len = $urandom_range(1, 20);
            rnd_din = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) begin
                applyStimulus(1'b1, rnd_din, 1);
            end
            applyStimulus(1'b0, rnd_din, run_len);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
